// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave
//   AXI4 responder backed by a word-addressed 32-bit register array. Read and
//   write channels run independent FSMs, one burst in flight per channel.
//   INCR/FIXED bursts up to 256 beats, byte strobes, ID echo. WRAP and the
//   reserved burst type step like INCR and answer SLVERR on every beat.
//
// Ports
//   clock, reset          sole clock (posedge); async active-low reset
//   aw*                   write address channel (awready out, rest in)
//   w*                    write data channel (wready out, rest in)
//   b*                    write response channel (bready in, rest out)
//   ar*                   read address channel (arready out, rest in)
//   r*                    read data channel (rready in, rest out)
//
// Parameters
//   BASE_ADDR  byte address of word 0
//   AW         log2 of array depth in words (range = 4<<AW bytes)
//   READ_LAT   cycles from AR handshake to first rvalid (>=1)

module axi4_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          AW        = 12,
  parameter int          READ_LAT  = 1
) (
  input  logic        clock,
  input  logic        reset,
  // write address
  output logic        awready,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  // write data
  output logic        wready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  // write response
  input  logic        bready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  // read address
  output logic        arready,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  // read data
  input  logic        rready,
  output logic        rvalid,
  output logic [1:0]  rresp,
  output logic [31:0] rdata,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [32:0] RANGE   = 33'd4 << AW;
  // R_LAT dwells READ_LAT-1 cycles; counter runs 0..LAT_END
  localparam logic [7:0]  LAT_END = 8'((READ_LAT > 1) ? (READ_LAT - 2) : 0);
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  SLVERR  = 2'b10;

  logic [31:0] mem [DEPTH];

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return ({1'b0, off} < RANGE);
  endfunction

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off[AW+1:2];
  endfunction

  // FIXED holds the address; INCR, WRAP and reserved all step by 1<<size
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (32'd1 << size);
  endfunction

  // size wider than the bus, WRAP or reserved burst type
  function automatic logic bad_attr(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'd2) || burst[1];
  endfunction

  // ---------------------------------------------------------------- read
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_t;

  r_state_t    r_state, r_state_n;
  logic [31:0] r_addr, r_addr_n;
  logic [7:0]  r_len, r_len_n, r_cnt, r_cnt_n, lat_cnt, lat_cnt_n;
  logic [2:0]  r_size, r_size_n;
  logic [1:0]  r_burst, r_burst_n;
  logic        rvalid_n, rlast_n;
  logic [1:0]  rresp_n;
  logic [31:0] rdata_n;
  logic [3:0]  rid_n;

  // beat loader: one place builds the registered R payload for any beat
  logic        ld, ld_err;
  logic [31:0] ld_addr;
  logic [7:0]  ld_cnt, ld_len;
  logic [2:0]  ld_size;
  logic [1:0]  ld_burst;

  assign arready = (r_state == R_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      lat_cnt <= '0;
      r_size  <= '0;
      r_burst <= '0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= OKAY;
      rdata   <= '0;
      rid     <= '0;
    end else begin
      r_state <= r_state_n;
      r_addr  <= r_addr_n;
      r_len   <= r_len_n;
      r_cnt   <= r_cnt_n;
      lat_cnt <= lat_cnt_n;
      r_size  <= r_size_n;
      r_burst <= r_burst_n;
      rvalid  <= rvalid_n;
      rlast   <= rlast_n;
      rresp   <= rresp_n;
      rdata   <= rdata_n;
      rid     <= rid_n;
    end
  end

  always_comb begin
    r_state_n = r_state;
    r_addr_n  = r_addr;
    r_len_n   = r_len;
    r_cnt_n   = r_cnt;
    lat_cnt_n = lat_cnt;
    r_size_n  = r_size;
    r_burst_n = r_burst;
    rvalid_n  = rvalid;
    rlast_n   = rlast;
    rresp_n   = rresp;
    rdata_n   = rdata;
    rid_n     = rid;
    ld        = 1'b0;
    ld_err    = 1'b0;
    ld_addr   = r_addr;
    ld_cnt    = r_cnt;
    ld_len    = r_len;
    ld_size   = r_size;
    ld_burst  = r_burst;

    case (r_state)
      R_IDLE: begin
        if (arvalid) begin
          r_addr_n  = araddr;
          r_len_n   = arlen;
          r_size_n  = arsize;
          r_burst_n = arburst;
          r_cnt_n   = '0;
          lat_cnt_n = '0;
          rid_n     = arid;
          ld_addr   = araddr;
          ld_cnt    = '0;
          ld_len    = arlen;
          ld_size   = arsize;
          ld_burst  = arburst;
          if (READ_LAT <= 1) begin
            ld        = 1'b1;
            r_state_n = R_DATA;
          end else begin
            r_state_n = R_LAT;
          end
        end
      end
      R_LAT: begin
        if (lat_cnt == LAT_END) begin
          ld        = 1'b1;
          r_state_n = R_DATA;
        end else begin
          lat_cnt_n = lat_cnt + 8'd1;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rlast) begin
            rvalid_n  = 1'b0;
            rlast_n   = 1'b0;
            r_state_n = R_IDLE;
          end else begin
            ld       = 1'b1;
            ld_addr  = next_addr(r_addr, r_size, r_burst);
            ld_cnt   = r_cnt + 8'd1;
            r_addr_n = ld_addr;
            r_cnt_n  = ld_cnt;
          end
        end
      end
      default: r_state_n = R_IDLE;
    endcase

    // array is read on the same edge a write may commit, so a colliding
    // beat sees the pre-write word
    if (ld) begin
      ld_err   = !in_range(ld_addr) || bad_attr(ld_size, ld_burst);
      rvalid_n = 1'b1;
      rdata_n  = ld_err ? 32'h0 : mem[widx(ld_addr)];
      rresp_n  = ld_err ? SLVERR : OKAY;
      rlast_n  = (ld_cnt == ld_len);
    end
  end

  // ---------------------------------------------------------------- write
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  w_state_t    w_state, w_state_n;
  logic [31:0] w_addr, w_addr_n;
  logic [7:0]  w_len, w_len_n, w_cnt, w_cnt_n;
  logic [2:0]  w_size, w_size_n;
  logic [1:0]  w_burst, w_burst_n;
  logic        w_err, w_err_n;
  logic        bvalid_n;
  logic [1:0]  bresp_n;
  logic [3:0]  bid_n;
  logic        beat_last, beat_err, mem_we;

  assign awready = (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
      bid     <= '0;
    end else begin
      w_state <= w_state_n;
      w_addr  <= w_addr_n;
      w_len   <= w_len_n;
      w_cnt   <= w_cnt_n;
      w_size  <= w_size_n;
      w_burst <= w_burst_n;
      w_err   <= w_err_n;
      bvalid  <= bvalid_n;
      bresp   <= bresp_n;
      bid     <= bid_n;
    end
  end

  always_comb begin
    w_state_n = w_state;
    w_addr_n  = w_addr;
    w_len_n   = w_len;
    w_cnt_n   = w_cnt;
    w_size_n  = w_size;
    w_burst_n = w_burst;
    w_err_n   = w_err;
    bvalid_n  = bvalid;
    bresp_n   = bresp;
    bid_n     = bid;
    mem_we    = 1'b0;
    // beat count ends the burst; a wlast that disagrees only flags an error
    beat_last = (w_cnt == w_len);
    beat_err  = !in_range(w_addr) || bad_attr(w_size, w_burst) || (wlast != beat_last);

    case (w_state)
      W_IDLE: begin
        if (awvalid) begin
          w_addr_n  = awaddr;
          w_len_n   = awlen;
          w_size_n  = awsize;
          w_burst_n = awburst;
          w_cnt_n   = '0;
          w_err_n   = 1'b0;
          bid_n     = awid;
          w_state_n = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          mem_we = in_range(w_addr);
          if (beat_last) begin
            bvalid_n  = 1'b1;
            bresp_n   = (w_err || beat_err) ? SLVERR : OKAY;
            w_state_n = W_RESP;
          end else begin
            w_err_n  = w_err || beat_err;
            w_addr_n = next_addr(w_addr, w_size, w_burst);
            w_cnt_n  = w_cnt + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_n  = 1'b0;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // array has no reset: contents survive a reset pulse
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[widx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb_axi4_sram_slave
//   Directed bench for axi4_sram_slave (default parameters). Expected R beats
//   and B responses are computed from a word model and queued when a request
//   is issued; negedge monitors pop and compare on each handshake and check
//   payload stability while rvalid is stalled.

module tb_axi4_sram_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clock, reset;
  logic        awready, awvalid;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wready, wvalid, wlast;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bready, bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arready, arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rready, rvalid, rlast;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic [3:0]  rid;

  axi4_sram_slave dut (
    .clock(clock), .reset(reset),
    .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
    .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [31:0] model [int];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  int          total = 0;
  int          bad   = 0;
  int          rr_mode = 0;   // 0: rready high, 1: toggle, 2: held low
  logic [31:0] last_rdata;
  logic        stall, st_last;
  logic [31:0] st_data;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic tb_in_range(input logic [31:0] a);
    return (a - BASE) < 32'h0000_4000;
  endfunction

  function automatic int tb_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // rready pattern generator
  initial begin
    rready = 1'b0;
    forever begin
      @(posedge clock); #2;
      case (rr_mode)
        0:       rready = 1'b1;
        1:       rready = ~rready;
        default: rready = 1'b0;
      endcase
    end
  end

  // R/B monitors: sample mid-cycle, when the next edge's handshake is settled
  always @(negedge clock) begin
    if (!reset) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("r_hold_valid", rvalid, 1'b1);
        chk("r_hold_data", rdata, st_data);
        chk("r_hold_last", rlast, st_last);
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          chk("r_extra_beat", rvalid, 1'b0);
        end else begin
          rbeat_t e;
          e = rq.pop_front();
          chk("r_data", rdata, e.d);
          chk("r_resp", rresp, e.resp);
          chk("r_last", rlast, e.last);
          chk("r_id", rid, e.id);
          last_rdata = rdata;
        end
      end
      stall   = rvalid && !rready;
      st_data = rdata;
      st_last = rlast;
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          chk("b_extra", bvalid, 1'b0);
        end else begin
          bexp_t b;
          b = bq.pop_front();
          chk("b_resp", bresp, b.resp);
          chk("b_id", bid, b.id);
        end
      end
    end
  end

  // write burst from wbuf/sbuf; early >= 0 raises wlast on that beat too
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int early);
    logic [31:0] a;
    logic        err, ok;
    int          n;
    a   = addr;
    err = (size > 3'd2) || burst[1];
    for (int i = 0; i <= int'(len); i++) begin
      if (!tb_in_range(a)) err = 1'b1;
      else for (int b = 0; b < 4; b++)
        if (sbuf[i][b]) model[tb_idx(a)][8*b +: 8] = wbuf[i][8*b +: 8];
      if (early == i && i != int'(len)) err = 1'b1;
      if (burst != 2'b00) a = a + (32'd1 << size);
    end
    bq.push_back('{resp: (err ? 2'b10 : 2'b00), id: id});
    @(posedge clock); #2;
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst;
    n = 0;
    do begin @(negedge clock); ok = awready; @(posedge clock); #2; n++; end while (!ok && n < 50);
    chk("aw_handshake", ok, 1'b1);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i];
      wlast  = (i == int'(len)) || (i == early);
      n = 0;
      do begin @(negedge clock); ok = wready; @(posedge clock); #2; n++; end while (!ok && n < 50);
      chk("w_handshake", ok, 1'b1);
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (bq.size() != 0 && n < 50) begin @(negedge clock); #1; n++; end
    chk("b_done", (bq.size() == 0), 1'b1);
  endtask

  // read burst; tight expects beat 0 one cycle after AR and one beat per clock
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic tight);
    logic [31:0] a;
    logic        attr, ok;
    rbeat_t      e;
    int          n;
    a    = addr;
    attr = (size > 3'd2) || burst[1];
    for (int i = 0; i <= int'(len); i++) begin
      ok     = tb_in_range(a) && !attr;
      e.d    = ok ? model[tb_idx(a)] : 32'h0;
      e.resp = ok ? 2'b00 : 2'b10;
      e.last = (i == int'(len));
      e.id   = id;
      rq.push_back(e);
      if (burst != 2'b00) a = a + (32'd1 << size);
    end
    @(posedge clock); #2;
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
    n = 0;
    do begin @(negedge clock); ok = arready; @(posedge clock); #2; n++; end while (!ok && n < 50);
    chk("ar_handshake", ok, 1'b1);
    arvalid = 1'b0;
    n = 0;
    while (rq.size() != 0 && n < 1000) begin
      @(negedge clock); #1; n++;
      if (tight && n == 1) chk("r_first_latency", rvalid, 1'b1);
    end
    chk("r_done", (rq.size() == 0), 1'b1);
    if (tight) chk("r_beat_cycles", n, int'(len) + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 1'b1;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
    stall = 1'b0; st_data = '0; st_last = 1'b0; last_rdata = '0;

    // reset state
    #3 reset = 1'b0;
    #1;
    chk("rst_awready", awready, 1'b1);
    chk("rst_arready", arready, 1'b1);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bresp_bid", {bresp, bid}, 6'h0);
    chk("rst_rresp_rid", {rresp, rid}, 6'h0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;

    // preload words 0..15; word 4 left zero for the strobe test
    for (int i = 0; i < 16; i++) begin
      wbuf[i] = (i == 4) ? 32'h0 : {8'hA0 + 8'(i), 8'h5A, 8'hC3, 8'(i * 7)};
      sbuf[i] = 4'hF;
    end
    do_write(BASE, 4'd1, 8'd15, 3'd2, 2'b01, -1);

    // single strobed write then read back
    wbuf[0] = 32'hDEAD_BEEF; sbuf[0] = 4'b0101;
    do_write(BASE + 32'h10, 4'd3, 8'd0, 3'd2, 2'b01, -1);
    do_read(BASE + 32'h10, 4'd2, 8'd0, 3'd2, 2'b01, 1'b1);
    chk("word4_strobed", last_rdata, 32'h00AD_00EF);

    // INCR read, 4 beats back to back
    do_read(BASE, 4'd5, 8'd3, 3'd2, 2'b01, 1'b1);

    // rready toggling over an 8-beat burst
    rr_mode = 1;
    do_read(BASE + 32'h4, 4'd6, 8'd7, 3'd2, 2'b01, 1'b0);
    rr_mode = 0;

    // FIXED write merges strobes into one word; FIXED read repeats it
    wbuf[0] = 32'h1111_1111; sbuf[0] = 4'b0001;
    wbuf[1] = 32'h2222_2222; sbuf[1] = 4'b0010;
    wbuf[2] = 32'h3333_3333; sbuf[2] = 4'b0100;
    do_write(BASE + 32'h20, 4'd6, 8'd2, 3'd2, 2'b00, -1);
    do_read(BASE + 32'h20, 4'd7, 8'd2, 3'd2, 2'b00, 1'b1);

    // attribute errors: size>2 read, reserved burst write
    do_read(BASE, 4'd2, 8'd1, 3'd3, 2'b01, 1'b1);
    wbuf[0] = 32'h0BAD_0001; wbuf[1] = 32'h0BAD_0002; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    do_write(BASE + 32'h30, 4'd7, 8'd1, 3'd2, 2'b11, -1);
    do_read(BASE + 32'h30, 4'd8, 8'd1, 3'd2, 2'b11, 1'b1);

    // range boundary: last word in range, next beat would alias word 0
    wbuf[0] = 32'hCAFE_F00D; wbuf[1] = 32'hFFFF_FFFF; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    do_write(BASE + 32'h3FFC, 4'd9, 8'd1, 3'd2, 2'b01, -1);
    do_read(BASE + 32'h3FFC, 4'd10, 8'd1, 3'd2, 2'b01, 1'b1);
    do_read(BASE + 32'h4000, 4'd11, 8'd0, 3'd2, 2'b01, 1'b1);
    do_read(BASE - 32'h4, 4'd12, 8'd0, 3'd2, 2'b01, 1'b1);
    do_read(BASE, 4'd13, 8'd0, 3'd2, 2'b01, 1'b1);

    // early wlast with a concurrent read burst
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'h7700_0000 + 32'(i); sbuf[i] = 4'hF;
    end
    fork
      do_write(BASE + 32'h100, 4'd14, 8'd3, 3'd2, 2'b01, 1);
      do_read(BASE, 4'd15, 8'd7, 3'd2, 2'b01, 1'b1);
    join
    do_read(BASE + 32'h100, 4'd1, 8'd3, 3'd2, 2'b01, 1'b1);

    // reset mid-burst: stalled read plus open write burst
    rr_mode = 2;
    @(posedge clock); #2;
    arvalid = 1'b1; araddr = BASE; arid = 4'd9; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
    @(posedge clock); #2;
    arvalid = 1'b0;
    awvalid = 1'b1; awaddr = BASE + 32'h40; awid = 4'd4; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01;
    @(posedge clock); #2;
    awvalid = 1'b0;
    @(negedge clock);
    chk("pre_rst_rvalid", rvalid, 1'b1);
    chk("pre_rst_arready", arready, 1'b0);
    chk("pre_rst_wready", wready, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_rvalid", rvalid, 1'b0);
    chk("mid_rst_bvalid", bvalid, 1'b0);
    chk("mid_rst_wready", wready, 1'b0);
    chk("mid_rst_awready", awready, 1'b1);
    chk("mid_rst_arready", arready, 1'b1);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    rr_mode = 0;
    rq.delete();
    bq.delete();
    do_read(BASE, 4'd3, 8'd7, 3'd2, 2'b01, 1'b1);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
